// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared FSM encoding, legal byte-enable patterns and defaults
package load_store_unit_pkg;

  localparam int TIMEOUT_DEFAULT = 255;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: be_legal = 1'b1;
      default:                                        be_legal = 1'b0;
    endcase
  endfunction

  // Store data sits in the low bits; replicate it so every enabled lane sees it.
  function automatic logic [31:0] replicate_store(input logic [3:0] be, input logic [31:0] data);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3: replicate_store = {4{data[7:0]}};
      BE_H0, BE_H1:               replicate_store = {2{data[15:0]}};
      default:                    replicate_store = data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the enabled lane of a read word and extends it to 32 bits
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_signed_extend,
  output logic [31:0] word
);

  // Lane pick followed by sign or zero extension; word loads pass through.
  always_comb begin
    word = 32'd0;
    case (mem_be)
      BE_B0: word = {{24{mem_signed_extend & mem_rdata[7]}},  mem_rdata[7:0]};
      BE_B1: word = {{24{mem_signed_extend & mem_rdata[15]}}, mem_rdata[15:8]};
      BE_B2: word = {{24{mem_signed_extend & mem_rdata[23]}}, mem_rdata[23:16]};
      BE_B3: word = {{24{mem_signed_extend & mem_rdata[31]}}, mem_rdata[31:24]};
      BE_H0: word = {{16{mem_signed_extend & mem_rdata[15]}}, mem_rdata[15:0]};
      BE_H1: word = {{16{mem_signed_extend & mem_rdata[31]}}, mem_rdata[31:16]};
      BE_W:  word = mem_rdata;
      default: word = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store engine with ack timeout
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic        mem_signed_extend,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        done,
  output logic        busy,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TIMEOUT_COUNT = TIMEOUT[7:0];

  logic [1:0]  state;
  logic        we_q;
  logic        sext_q;
  logic [3:0]  be_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] load_q;
  logic [7:0]  wait_count;
  logic [7:0]  wait_count_next;
  logic        timeout_hit;
  logic [31:0] aligned_word;

  // Byte offset is already encoded in dm_be, so the low address bits carry no extra information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  assign wait_count_next = wait_count + 8'd1;
  assign timeout_hit     = (wait_count_next == TIMEOUT_COUNT);

  load_align u_load_align (
    .mem_be            (be_q),
    .mem_rdata         (mem_rdata),
    .mem_signed_extend (sext_q),
    .word              (aligned_word)
  );

  // Request capture, access sequencing and timeout tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      we_q       <= 1'b0;
      sext_q     <= 1'b0;
      be_q       <= 4'd0;
      addr_q     <= 30'd0;
      wdata_q    <= 32'd0;
      load_q     <= 32'd0;
      wait_count <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (be_legal(dm_be)) begin
              we_q       <= dm_we;
              sext_q     <= mem_signed_extend;
              be_q       <= dm_be;
              addr_q     <= addr[31:2];
              wdata_q    <= replicate_store(dm_be, store_data);
              wait_count <= 8'd0;
              state      <= ST_ACCESS;
            end else begin
              state <= ST_ERR;
            end
          end
        end
        ST_ACCESS: begin
          // An ack in the same cycle as the timeout still completes the access.
          if (mem_ack) begin
            load_q <= we_q ? 32'd0 : aligned_word;
            state  <= ST_RESP;
          end else begin
            wait_count <= wait_count_next;
            if (timeout_hit) begin
              state <= ST_ERR;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = (state == ST_ACCESS);
  assign mem_we    = (state == ST_ACCESS) & we_q;
  assign busy      = (state == ST_ACCESS);
  assign done      = (state == ST_RESP);
  assign bus_error = (state == ST_ERR);
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign load_data = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with directed vectors
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic        mem_signed_extend;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        done;
  logic        busy;
  logic        bus_error;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .dm_we             (dm_we),
    .dm_be             (dm_be),
    .mem_signed_extend (mem_signed_extend),
    .addr              (addr),
    .store_data        (store_data),
    .load_data         (load_data),
    .done              (done),
    .busy              (busy),
    .bus_error         (bus_error),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_be            (mem_be),
    .mem_wdata         (mem_wdata),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every done or bus_error pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (done === 1'b1 || bus_error === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=done%0b/err%0b required=none", done, bus_error);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_kind", {30'd0, bus_error, done}, {30'd0, e.err, ~e.err});
        if (!e.err) chk("load_data", load_data, e.data);
      end
    end
  end

  task automatic issue(input logic we, input logic [3:0] be, input logic sext,
                       input logic [31:0] a, input logic [31:0] sd);
    @(posedge clk); #1;
    start = 1'b1; dm_we = we; dm_be = be; mem_signed_extend = sext; addr = a; store_data = sd;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic we, input logic [3:0] be, input logic sext,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                        input int delay, input logic poke,
                        input logic [31:0] exp_ld, input logic [31:0] exp_wd);
    exp_q.push_back({1'b0, exp_ld});
    issue(we, be, sext, a, sd);
    chk({tag, "_req"},   {31'd0, mem_req}, 32'd1);
    chk({tag, "_we"},    {31'd0, mem_we}, {31'd0, we});
    chk({tag, "_addr"},  {2'd0, mem_addr}, {2'd0, a[31:2]});
    chk({tag, "_be"},    {28'd0, mem_be}, {28'd0, be});
    chk({tag, "_wdata"}, mem_wdata, exp_wd);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
    for (int i = 0; i < delay; i++) begin
      if (poke && i == 0) begin
        start = 1'b1; dm_be = 4'b1111; addr = 32'hFFFF_FFF0; dm_we = ~we;
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_hold_req"}, {31'd0, mem_req}, 32'd1);
      chk({tag, "_hold_addr"}, {2'd0, mem_addr}, {2'd0, a[31:2]});
    end
    mem_ack = 1'b1; mem_rdata = rd;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk({tag, "_done_lat"}, {31'd0, done}, 32'd1);
    chk({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; dm_we = 1'b0; dm_be = 4'd0; mem_signed_extend = 1'b0;
    addr = 32'd0; store_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    #12;
    chk("rst_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {30'd0, done, bus_error}, 32'd0);
    chk("rst_addr",  {2'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_load",  load_data, 32'd0);
    @(posedge clk); #1; reset = 1'b0;

    // Ack while idle must be ignored.
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1; mem_ack = 1'b0;
    chk("idle_ack_req", {31'd0, mem_req}, 32'd0);

    run_op("lb",  1'b0, 4'b1000, 1'b1, 32'h0000_0103, 32'h0, 32'h80AA_55CC, 0, 1'b0, 32'hFFFF_FF80, 32'h0);
    run_op("lhu", 1'b0, 4'b1100, 1'b0, 32'h0000_0202, 32'h0, 32'hBEEF_1234, 1, 1'b0, 32'h0000_BEEF, 32'h0);
    run_op("sb",  1'b1, 4'b0100, 1'b0, 32'h0000_0302, 32'h1234_56A5, 32'hFFFF_FFFF, 0, 1'b0, 32'h0, 32'hA5A5_A5A5);
    run_op("sh",  1'b1, 4'b1100, 1'b0, 32'h0000_0402, 32'h0000_ABCD, 32'hFFFF_FFFF, 2, 1'b1, 32'h0, 32'hABCD_ABCD);
    run_op("sw",  1'b1, 4'b1111, 1'b0, 32'h0000_0500, 32'h1122_3344, 32'hFFFF_FFFF, 0, 1'b0, 32'h0, 32'h1122_3344);
    run_op("lh",  1'b0, 4'b0011, 1'b1, 32'h0000_0600, 32'h0, 32'h1234_8001, 0, 1'b0, 32'hFFFF_8001, 32'h0);
    run_op("lbu", 1'b0, 4'b0010, 1'b0, 32'h0000_0701, 32'h0, 32'h0000_F100, 3, 1'b0, 32'h0000_00F1, 32'h0);
    run_op("lw",  1'b0, 4'b1111, 1'b1, 32'h0000_0800, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 32'hDEAD_BEEF, 32'h0);

    // Timeout with no ack.
    exp_q.push_back({1'b1, 32'h0});
    issue(1'b0, 4'b1111, 1'b0, 32'h0000_0900, 32'h0);
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("to_req_cycles", n, 32'd4);
    chk("to_bus_error", {31'd0, bus_error}, 32'd1);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_done", {31'd0, done}, 32'd0);

    // Illegal byte enables.
    exp_q.push_back({1'b1, 32'h0});
    issue(1'b0, 4'b0110, 1'b0, 32'h0000_0A00, 32'h0);
    chk("ill_req", {31'd0, mem_req}, 32'd0);
    chk("ill_bus_error", {31'd0, bus_error}, 32'd1);
    chk("ill_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of an access, followed by a late ack.
    issue(1'b0, 4'b1111, 1'b0, 32'h0000_0B00, 32'h0);
    chk("rstmid_req_before", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmid_req", {31'd0, mem_req}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_pulses", {30'd0, done, bus_error}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_no_done", {30'd0, done, bus_error}, 32'd0);

    run_op("post_rst", 1'b0, 4'b0001, 1'b1, 32'h0000_0C00, 32'h0, 32'h0000_007F, 0, 1'b0, 32'h0000_007F, 32'h0);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles to wait for mem_ack before aborting; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request pulse from execute stage; sampled only in IDLE.
REQ-005 dm_we  input  1  1 = store, 0 = load (decoder encoding).
REQ-006 dm_be  input  4  byte-lane enables from decoder, already address-aligned.
REQ-007 mem_signed_extend  input  1  load result sign-extended when 1, zero-extended when 0.
REQ-008 addr  input  32  effective byte address.
REQ-009 store_data  input  32  rs2 value; the byte or half occupies the low bits.
REQ-010 load_data  output  32  extended load result; valid while done=1.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 busy  output  1  high from the cycle after start is accepted until done or bus_error.
REQ-013 bus_error  output  1  one-cycle pulse on timeout or illegal dm_be.
REQ-014 mem_req  output  1  memory request, held until ack.
REQ-015 mem_we  output  1  memory write strobe.
REQ-016 mem_addr  output  30  word address, equal to addr[31:2].
REQ-017 mem_be  output  4  byte enables driven to memory.
REQ-018 mem_wdata  output  32  lane-replicated store data.
REQ-019 mem_ack  input  1  memory completion; for reads, mem_rdata is valid in the same cycle.
REQ-020 mem_rdata  input  32  memory read word.

Function
REQ-021 FSM states: IDLE, ACCESS, RESP, ERR; encoding comes from the shared package.
REQ-022 IDLE with start=1 and legal dm_be: capture dm_we, dm_be, mem_signed_extend, addr and store_data; next state is ACCESS.
REQ-023 Legal dm_be values: 0001, 0010, 0100, 1000 (byte); 0011, 1100 (half); 1111 (word).
REQ-024 Any other dm_be, including 0000, goes to ERR: mem_req is never asserted and bus_error pulses in the next cycle.
REQ-025 ACCESS: mem_req=1 and mem_we=captured dm_we; mem_addr, mem_be and mem_wdata are driven from registered values only.
REQ-026 Byte store: mem_wdata = store_data[7:0] replicated to all four lanes; half store: store_data[15:0] replicated twice; word store: unchanged.
REQ-027 mem_ack=1 in ACCESS: register load_data; next state is RESP. RESP drives done=1 for one cycle, then returns to IDLE.
REQ-028 Load extraction: select the lane given by mem_be, then extend to 32 bits according to mem_signed_extend. Word loads pass through unchanged. Stores return load_data=0.
REQ-029 Timeout counter (8-bit) clears on entry to ACCESS and increments each ACCESS cycle without ack. If it reaches TIMEOUT, mem_req drops and the next state is ERR; ERR pulses bus_error for one cycle, then returns to IDLE.
REQ-030 If mem_ack arrives in the same cycle the counter reaches TIMEOUT, ack wins and the access completes normally.
REQ-031 start outside IDLE is ignored; there is no queueing.
REQ-032 Latency: start in cycle N, mem_req from N+1. If ack arrives in cycle M, done pulses in M+1. Zero-wait memory gives done at N+2.
REQ-033 mem_ack outside ACCESS is ignored.

Reset
REQ-034 reset immediately forces: state IDLE; mem_req, mem_we, done, busy and bus_error to 0; mem_addr, mem_be, mem_wdata and load_data to 0; timeout counter to 0.
REQ-035 reset during ACCESS abandons the transaction with no done or bus_error. The first start after reset deasserts is accepted.

Structure
REQ-036 A shared package holds the FSM state constants, the seven legal dm_be patterns and the TIMEOUT default.
REQ-037 Lane selection and extension live in the combinational sub-module load_align (inputs mem_be, mem_rdata, mem_signed_extend; output 32-bit word). load_store_unit instantiates it once.

Verification
REQ-038 LB: addr=0x103, dm_be=1000, signed=1, mem_rdata=0x80AA55CC with ack in the first ACCESS cycle -> load_data=0xFFFFFF80, done at N+2.
REQ-039 LHU: addr=0x202, dm_be=1100, signed=0, mem_rdata=0xBEEF1234 -> load_data=0x0000BEEF, mem_addr=0x80.
REQ-040 SB: store_data=0x123456A5, dm_be=0100 -> mem_wdata=0xA5A5A5A5, mem_we=1, mem_be=0100, done after ack.
REQ-041 Timeout: TIMEOUT=4, no ack -> mem_req high for 4 cycles, bus_error pulses once, busy falls, and no done pulse occurs.
REQ-042 Illegal dm_be=0110 -> no mem_req, bus_error pulses at N+1. A start pulse during a busy access is ignored.
REQ-043 reset asserted mid-ACCESS with ack 3 cycles later -> mem_req=0 immediately, and neither done nor bus_error pulses.
